dvb_cmd_parser: RTL and testbench
=================================

# dvb_cmd_parser

Downstream consumer of the DVB-side command byte stream from the PCIe/DVB command bridge (`cmd_dvb_dout`/`cmd_dvb_dout_en`). It parses framed commands, turns their payload into 16-bit register writes for the per-channel TS-merge configuration, and returns a 4-byte acknowledge frame. The acknowledge frame goes back into the bridge's `cmd_dvb_din`/`cmd_dvb_din_en` input. Runs entirely in the `clk_main` domain.

## Interface
Parameters:
- `OPCODE_WR`, 8'h40: opcode accepted as a register-write command.
- `MAX_WORDS`, 64: maximum payload words written per frame.

Ports:
- `clk_main`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset. Synchronous and active-high.
- `cmd_din`  in  8  command byte. Valid when `cmd_din_en`=1.
- `cmd_din_en`  in  1  frame enable. High for consecutive cycles for the whole frame; a low cycle ends the frame.
- `reg_wr_addr`  out  12  {channel[3:0], index[7:0]}.
- `reg_wr_data`  out  16  write data, big-endian word.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `ack_dout`  out  8  acknowledge byte.
- `ack_dout_en`  out  1  acknowledge byte valid; 4 consecutive cycles per frame.
- `busy`  out  1  high from the first header byte until the last ack byte.

## Operation
Frame layout:
- byte0: opcode.
- byte1: channel; low 4 bits used, upper bits ignored.
- byte2: start register index.
- byte3: flags; stored but unused.
- bytes 4..: payload, taken as pairs (high byte, then low byte) forming one 16-bit word.

State machine:
- IDLE: when `cmd_din_en`=1, latch opcode and go to HDR.
- HDR: latch bytes 1..3. Then go to PAY_HI if opcode == `OPCODE_WR`, otherwise to DROP.
- PAY_HI: latch the high byte, go to PAY_LO.
- PAY_LO: issue the write and return to PAY_HI. Index increments modulo 256 (wraps from 0xFF to 0x00); channel does not change.
- DROP: consume bytes with no writes.
- ACK: emit 4 bytes, then return to IDLE.
- From HDR, PAY_HI, PAY_LO or DROP, a cycle with `cmd_din_en`=0 moves to ACK.

Word counter `wcnt` is 8 bits. Once `wcnt` == `MAX_WORDS`, further words are discarded (no write), but the frame is still consumed.

Acknowledge frame:
- byte0: 8'hC0 | opcode[3:0].
- byte1: channel.
- byte2: `wcnt`.
- byte3: status.

Status codes, first error wins:
- 00: OK.
- 01: bad opcode (no writes).
- 02: short header, frame under 4 bytes (no writes).
- 03: odd payload; the trailing byte is dropped and earlier words are already written.
- 04: overflow, more than `MAX_WORDS` words.

Boundary rules:
- A frame that starts while in ACK (`cmd_din_en` rising during ack output) is ignored in full. After the ack completes, the block stays idle until `cmd_din_en` has been low for at least one cycle.
- A zero-payload write frame produces an ack with count 0 and status 00.
- `rst` mid-frame or mid-ack:
  - Abort immediately; no ack is sent and all outputs go to their reset values.
  - If `cmd_din_en` is still high after reset, the rest of that frame is ignored until `cmd_din_en` goes low.

## Timing
- Reset values: `reg_wr_addr`=0, `reg_wr_data`=0, `reg_wr_en`=0, `ack_dout`=0, `ack_dout_en`=0, `busy`=0. All outputs are registered.
- `reg_wr_en` pulses in the cycle after the low byte is sampled.
- `busy` rises the cycle after byte0 is sampled.
- First ack byte appears 1 cycle after the first `cmd_din_en`=0 sample. The four ack bytes are back-to-back, with no gaps.
- `busy` falls in the cycle after the last ack byte.
- Write-to-write spacing is at least 2 cycles, because of byte pairing.
- During ack output, `ack_dout` holds 0 on cycles where `ack_dout_en`=0.

## Structure
- Shared package `dvb_cmd_pkg`:
  - state enum;
  - ack status constants;
  - ack byte0 prefix 8'hC0;
  - header length 4.
- One natural sub-module, `dvb_ack_tx`: a 4-byte load-and-shift serializer with a done pulse, instantiated once.

## Test plan
- Normal write: `cmd_din` = 40 01 00 01 then 00..09 on consecutive cycles (14 bytes), then `cmd_din_en` low.
  - Writes: addr 0x100→0x0001, 0x101→0x0203, 0x102→0x0405, 0x103→0x0607, 0x104→0x0809.
  - Ack: C0 01 05 00.
- Odd payload: 40 02 10 00 AA BB CC.
  - One write: 0x210→0xAABB.
  - Ack: C0 02 01 03.
- Bad opcode and short header:
  - 55 03 00 00 11 22 → no writes; ack C5 03 00 01.
  - 40 03 → no writes; ack C0 03 00 02.
- Wrap and overflow: `MAX_WORDS`=4; frame 40 00 FE 00 followed by 12 payload bytes.
  - Writes to 0x0FE, 0x0FF, 0x000, 0x001 only.
  - Ack: C0 00 04 04.
- Reset mid-frame: assert `rst` for 1 cycle after byte 6 while `cmd_din_en` stays high.
  - No further writes and no ack.
  - Next clean frame is parsed normally.
- Overlap: raise `cmd_din_en` during the 2nd ack byte.
  - Ack completes intact.
  - Overlapping frame is ignored.
  - Next frame after an idle cycle is accepted.

Source files
------------

// File: rtl/dvb_cmd_pkg.sv
// Shared definitions for the DVB command parser: FSM states, ack status
// codes, ack byte0 prefix and header length.
package dvb_cmd_pkg;

  localparam int unsigned HDR_LEN = 4;

  localparam logic [7:0] ACK_PREFIX = 8'hC0;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BAD_OP = 8'h01;
  localparam logic [7:0] ST_SHORT  = 8'h02;
  localparam logic [7:0] ST_ODD    = 8'h03;
  localparam logic [7:0] ST_OVF    = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY_HI,
    S_PAY_LO,
    S_DROP,
    S_ACK,
    S_WAIT_LOW
  } state_t;

  // First acknowledge byte: fixed prefix tagged with the opcode's low nibble.
  function automatic logic [7:0] ack_byte0(input logic [3:0] op_lo);
    return ACK_PREFIX | {4'h0, op_lo};
  endfunction

endpackage

// File: rtl/dvb_cmd_parser_if.sv
// Bus bundle between the command bridge and the parser.
//   cmd_din/cmd_din_en         : framed command byte stream into the parser
//   reg_wr_addr/data/en        : 16-bit register write port
//   ack_dout/ack_dout_en       : 4-byte acknowledge stream back to the bridge
//   busy                       : parser is handling a frame or its ack
interface dvb_cmd_parser_if;
  logic [7:0]  cmd_din;
  logic        cmd_din_en;
  logic [11:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_en;
  logic [7:0]  ack_dout;
  logic        ack_dout_en;
  logic        busy;

  modport master (
    output cmd_din, cmd_din_en,
    input  reg_wr_addr, reg_wr_data, reg_wr_en, ack_dout, ack_dout_en, busy
  );

  modport slave (
    input  cmd_din, cmd_din_en,
    output reg_wr_addr, reg_wr_data, reg_wr_en, ack_dout, ack_dout_en, busy
  );
endinterface

// File: rtl/dvb_ack_tx.sv
// Acknowledge serializer: loads a 4-byte frame and shifts it out MSB byte
// first on consecutive cycles; done pulses with the last byte.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture frame; first byte is output on the next cycle
//   frame      : {byte0, byte1, byte2, byte3}
//   dout/dout_en : serialized byte and its valid (dout is 0 when not valid)
//   done       : high in the cycle the last byte is presented
module dvb_ack_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] frame,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        done
);

  logic [23:0] sh;
  logic [1:0]  cnt;

  // Load-and-shift; cnt counts bytes still to follow the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout    <= 8'h00;
      dout_en <= 1'b0;
      done    <= 1'b0;
      sh      <= 24'h0;
      cnt     <= 2'd0;
    end else if (load) begin
      dout    <= frame[31:24];
      dout_en <= 1'b1;
      done    <= 1'b0;
      sh      <= frame[23:0];
      cnt     <= 2'd3;
    end else if (cnt != 2'd0) begin
      dout    <= sh[23:16];
      sh      <= {sh[15:0], 8'h00};
      cnt     <= cnt - 2'd1;
      done    <= (cnt == 2'd1);
    end else begin
      dout    <= 8'h00;
      dout_en <= 1'b0;
      done    <= 1'b0;
    end
  end

endmodule

// File: rtl/dvb_cmd_parser.sv
// DVB command parser: turns framed write commands into 16-bit register
// writes for the per-channel TS-merge configuration and returns a 4-byte ack.
//   clk_main, rst : clock, synchronous active-high reset
//   bus (slave)   : cmd_din/cmd_din_en in; reg_wr_*, ack_dout*, busy out
module dvb_cmd_parser
  import dvb_cmd_pkg::*;
#(
  parameter logic [7:0]  OPCODE_WR = 8'h40,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic             clk_main,
  input  logic             rst,
  dvb_cmd_parser_if.slave  bus
);

  state_t     state;
  logic [3:0] op_lo;
  logic [3:0] chan;
  logic [7:0] idx;
  logic [7:0] wcnt;
  logic [7:0] hi_byte;
  logic [7:0] status;
  logic [1:0] hcnt;

  logic        ack_load_c;
  logic [7:0]  ack_status_c;
  logic        ack_done;

  // Frame end (enable low while parsing) triggers the ack; errors that are
  // only known at the end (short header, odd payload) resolve here unless an
  // earlier error already claimed the status.
  always_comb begin
    ack_load_c   = 1'b0;
    ack_status_c = status;
    if (!bus.cmd_din_en && (state == S_HDR || state == S_PAY_HI ||
                            state == S_PAY_LO || state == S_DROP)) begin
      ack_load_c = 1'b1;
    end
    if (status == ST_OK) begin
      if (state == S_HDR)        ack_status_c = ST_SHORT;
      else if (state == S_PAY_LO) ack_status_c = ST_ODD;
    end
  end

  // Parser FSM with registered write port and busy.
  always_ff @(posedge clk_main) begin
    if (rst) begin
      // A frame still in flight across reset is skipped until enable drops.
      state           <= bus.cmd_din_en ? S_WAIT_LOW : S_IDLE;
      op_lo           <= 4'h0;
      chan            <= 4'h0;
      idx             <= 8'h00;
      wcnt            <= 8'h00;
      hi_byte         <= 8'h00;
      status          <= ST_OK;
      hcnt            <= 2'd0;
      bus.reg_wr_addr <= 12'h000;
      bus.reg_wr_data <= 16'h0000;
      bus.reg_wr_en   <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.reg_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_din_en) begin
            op_lo    <= bus.cmd_din[3:0];
            chan     <= 4'h0;
            idx      <= 8'h00;
            wcnt     <= 8'h00;
            hcnt     <= 2'd1;
            status   <= (bus.cmd_din == OPCODE_WR) ? ST_OK : ST_BAD_OP;
            bus.busy <= 1'b1;
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (!bus.cmd_din_en) begin
            state <= S_ACK;
          end else begin
            // Byte 3 (flags) carries nothing the parser acts on.
            case (hcnt)
              2'd1:    chan <= bus.cmd_din[3:0];
              2'd2:    idx  <= bus.cmd_din;
              default: ;
            endcase
            hcnt <= hcnt + 2'd1;
            if (hcnt == 2'(HDR_LEN - 1)) begin
              state <= (status == ST_OK) ? S_PAY_HI : S_DROP;
            end
          end
        end
        S_PAY_HI: begin
          if (!bus.cmd_din_en) begin
            state <= S_ACK;
          end else begin
            hi_byte <= bus.cmd_din;
            state   <= S_PAY_LO;
          end
        end
        S_PAY_LO: begin
          if (!bus.cmd_din_en) begin
            state <= S_ACK;
          end else begin
            if (wcnt != 8'(MAX_WORDS)) begin
              bus.reg_wr_en   <= 1'b1;
              bus.reg_wr_addr <= {chan, idx};
              bus.reg_wr_data <= {hi_byte, bus.cmd_din};
              idx             <= idx + 8'd1;
              wcnt            <= wcnt + 8'd1;
            end else if (status == ST_OK) begin
              status <= ST_OVF;
            end
            state <= S_PAY_HI;
          end
        end
        S_DROP: begin
          if (!bus.cmd_din_en) state <= S_ACK;
        end
        S_ACK: begin
          // A frame that began during the ack is skipped in full.
          if (ack_done) begin
            bus.busy <= 1'b0;
            state    <= bus.cmd_din_en ? S_WAIT_LOW : S_IDLE;
          end
        end
        S_WAIT_LOW: begin
          if (!bus.cmd_din_en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  dvb_ack_tx u_ack_tx (
    .clk     (clk_main),
    .rst     (rst),
    .load    (ack_load_c),
    .frame   ({ack_byte0(op_lo), {4'h0, chan}, wcnt, ack_status_c}),
    .dout    (bus.ack_dout),
    .dout_en (bus.ack_dout_en),
    .done    (ack_done)
  );

endmodule

// File: tb/tb_dvb_cmd_parser.sv
// Bench for dvb_cmd_parser: two instances (MAX_WORDS 64 and 4) see the same
// byte stream; results are compared against a frame-level reference model.
module tb_dvb_cmd_parser;

  typedef struct { int d; int c; logic [11:0] a; logic [15:0] v; } wr_ev_t;
  typedef struct { int d; int c; logic [7:0] b; } ak_ev_t;
  typedef struct { int d; int c; logic v; } bz_ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  wr_ev_t wr_q[$];
  ak_ev_t ak_q[$];
  bz_ev_t bz_q[$];
  logic   bz_pa = 1'b0;
  logic   bz_pb = 1'b0;

  logic [27:0] m_wr[$];
  logic [7:0]  m_ack[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dvb_cmd_parser_if ifa ();
  dvb_cmd_parser_if ifb ();

  dvb_cmd_parser #(.OPCODE_WR(8'h40), .MAX_WORDS(64)) dut_a (
    .clk_main (clk),
    .rst      (rst),
    .bus      (ifa)
  );

  dvb_cmd_parser #(.OPCODE_WR(8'h40), .MAX_WORDS(4)) dut_b (
    .clk_main (clk),
    .rst      (rst),
    .bus      (ifb)
  );

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifa.reg_wr_en === 1'b1) wr_q.push_back('{d:0, c:cyc, a:ifa.reg_wr_addr, v:ifa.reg_wr_data});
    if (ifb.reg_wr_en === 1'b1) wr_q.push_back('{d:1, c:cyc, a:ifb.reg_wr_addr, v:ifb.reg_wr_data});
    if (ifa.ack_dout_en === 1'b1) ak_q.push_back('{d:0, c:cyc, b:ifa.ack_dout});
    if (ifb.ack_dout_en === 1'b1) ak_q.push_back('{d:1, c:cyc, b:ifb.ack_dout});
    if (ifa.busy !== bz_pa) begin bz_q.push_back('{d:0, c:cyc, v:ifa.busy}); bz_pa = ifa.busy; end
    if (ifb.busy !== bz_pb) begin bz_q.push_back('{d:1, c:cyc, v:ifb.busy}); bz_pb = ifb.busy; end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic set_in(input logic en, input logic [7:0] b);
    ifa.cmd_din_en = en; ifa.cmd_din = b;
    ifb.cmd_din_en = en; ifb.cmd_din = b;
  endtask

  task automatic clear_mon();
    wr_q.delete(); ak_q.delete(); bz_q.delete();
  endtask

  // Drives one frame; s0 = edge that samples byte0, s_end = edge that samples enable low.
  task automatic drive_frame(input logic [7:0] fr[$], output int s0, output int s_end);
    s0 = 0;
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) s0 = cyc + 1;
      set_in(1'b1, fr[i]);
    end
    @(posedge clk); #1;
    s_end = cyc + 1;
    set_in(1'b0, 8'h00);
  endtask

  // Frame-level reference: expected writes and ack from the frame bytes alone.
  task automatic model(input logic [7:0] fr[$], input int maxw);
    int n, words, wr_n;
    logic [7:0] op, idx, st;
    logic [3:0] ch;
    n = fr.size();
    op = fr[0];
    ch = (n > 1) ? fr[1][3:0] : 4'h0;
    idx = (n > 2) ? fr[2] : 8'h00;
    wr_n = 0;
    m_wr.delete();
    if (op != 8'h40) st = 8'h01;
    else if (n < 4) st = 8'h02;
    else begin
      words = (n - 4) / 2;
      wr_n = (words > maxw) ? maxw : words;
      if (words > maxw) st = 8'h04;
      else if (((n - 4) % 2) != 0) st = 8'h03;
      else st = 8'h00;
      for (int j = 0; j < wr_n; j++)
        m_wr.push_back({ch, 8'(idx + 8'(j)), fr[4 + 2*j], fr[5 + 2*j]});
    end
    m_ack[0] = 8'hC0 | {4'h0, op[3:0]};
    m_ack[1] = {4'h0, ch};
    m_ack[2] = 8'(wr_n);
    m_ack[3] = st;
  endtask

  task automatic test_reset();
    logic [11:0] ad; logic [15:0] dt; logic we, ae, bz; logic [7:0] ak;
    rst = 1'b1;
    set_in(1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      ad = d == 0 ? ifa.reg_wr_addr : ifb.reg_wr_addr;
      dt = d == 0 ? ifa.reg_wr_data : ifb.reg_wr_data;
      we = d == 0 ? ifa.reg_wr_en : ifb.reg_wr_en;
      ak = d == 0 ? ifa.ack_dout : ifb.ack_dout;
      ae = d == 0 ? ifa.ack_dout_en : ifb.ack_dout_en;
      bz = d == 0 ? ifa.busy : ifb.busy;
      n_checks++; if (ad !== 12'h0) begin n_err++; $display("FAIL reset_addr dut%0d: got %h want 000", d, ad); end
      n_checks++; if (dt !== 16'h0) begin n_err++; $display("FAIL reset_data dut%0d: got %h want 0000", d, dt); end
      n_checks++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_wr_en dut%0d: got %b want 0", d, we); end
      n_checks++; if (ak !== 8'h0) begin n_err++; $display("FAIL reset_ack_dout dut%0d: got %h want 00", d, ak); end
      n_checks++; if (ae !== 1'b0) begin n_err++; $display("FAIL reset_ack_en dut%0d: got %b want 0", d, ae); end
      n_checks++; if (bz !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d: got %b want 0", d, bz); end
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Test-plan frames followed by random ones, checked on both instances.
  task automatic test_frames(input int n_rand);
    logic [7:0] fr[$];
    int s0, se, got, len, bi;
    logic [7:0] dq; logic de;
    for (int k = 0; k < 5 + n_rand; k++) begin
      fr.delete();
      case (k)
        0: begin fr = '{8'h40, 8'h01, 8'h00, 8'h01}; for (int b = 0; b < 10; b++) fr.push_back(8'(b)); end
        1: fr = '{8'h40, 8'h02, 8'h10, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        2: fr = '{8'h55, 8'h03, 8'h00, 8'h00, 8'h11, 8'h22};
        3: fr = '{8'h40, 8'h03};
        4: begin fr = '{8'h40, 8'h00, 8'hFE, 8'h00}; for (int b = 0; b < 12; b++) fr.push_back(8'($urandom)); end
        default: begin
          len = $urandom_range(1, 22);
          fr.push_back(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h40);
          for (int i = 1; i < len; i++)
            fr.push_back((i == 2 && $urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom));
        end
      endcase
      clear_mon();
      drive_frame(fr, s0, se);
      repeat (7) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        model(fr, d == 0 ? 64 : 4);
        got = 0;
        foreach (wr_q[i]) if (wr_q[i].d == d) begin
          if (got < m_wr.size()) begin
            n_checks++;
            if ({wr_q[i].a, wr_q[i].v} !== m_wr[got] || wr_q[i].c != s0 + 5 + 2*got) begin
              n_err++;
              $display("FAIL write frame%0d dut%0d #%0d: got %h/%h at %0d, want %h/%h at %0d", k, d, got,
                       wr_q[i].a, wr_q[i].v, wr_q[i].c, m_wr[got][27:16], m_wr[got][15:0], s0 + 5 + 2*got);
            end
          end
          got++;
        end
        n_checks++;
        if (got != m_wr.size()) begin n_err++; $display("FAIL write_count frame%0d dut%0d: got %0d want %0d", k, d, got, m_wr.size()); end
        got = 0;
        foreach (ak_q[i]) if (ak_q[i].d == d) begin
          if (got < 4) begin
            bi = got;
            n_checks++;
            if (ak_q[i].b !== m_ack[bi] || ak_q[i].c != se + got) begin
              n_err++;
              $display("FAIL ack frame%0d dut%0d byte%0d: got %h at %0d, want %h at %0d", k, d, got, ak_q[i].b, ak_q[i].c, m_ack[bi], se + got);
            end
          end
          got++;
        end
        n_checks++;
        if (got != 4) begin n_err++; $display("FAIL ack_count frame%0d dut%0d: got %0d want 4", k, d, got); end
        got = 0;
        foreach (bz_q[i]) if (bz_q[i].d == d) begin
          n_checks++;
          if (got == 0 && (bz_q[i].v !== 1'b1 || bz_q[i].c != s0)) begin
            n_err++; $display("FAIL busy_rise frame%0d dut%0d: got %b at %0d want 1 at %0d", k, d, bz_q[i].v, bz_q[i].c, s0);
          end else if (got == 1 && (bz_q[i].v !== 1'b0 || bz_q[i].c != se + 4)) begin
            n_err++; $display("FAIL busy_fall frame%0d dut%0d: got %b at %0d want 0 at %0d", k, d, bz_q[i].v, bz_q[i].c, se + 4);
          end else if (got > 1) begin
            n_err++; $display("FAIL busy_extra frame%0d dut%0d: toggle to %b at %0d", k, d, bz_q[i].v, bz_q[i].c);
          end
          got++;
        end
        n_checks++;
        if (got != 2) begin n_err++; $display("FAIL busy_edges frame%0d dut%0d: got %0d want 2", k, d, got); end
        dq = d == 0 ? ifa.ack_dout : ifb.ack_dout;
        de = d == 0 ? ifa.ack_dout_en : ifb.ack_dout_en;
        n_checks++;
        if (dq !== 8'h00 || de !== 1'b0) begin n_err++; $display("FAIL ack_idle frame%0d dut%0d: got %h/%b want 00/0", k, d, dq, de); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] fr[$];
    int s0, se, got;
    fr = '{8'h40, 8'h05, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_mon();
    s0 = 0;
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) s0 = cyc + 1;
      if (i == 8) begin
        n_checks++;
        if (ifa.reg_wr_addr !== 12'h0 || ifa.reg_wr_data !== 16'h0 || ifa.reg_wr_en !== 1'b0 ||
            ifa.ack_dout !== 8'h0 || ifa.ack_dout_en !== 1'b0 || ifa.busy !== 1'b0) begin
          n_err++;
          $display("FAIL midreset_outputs: got addr %h data %h we %b ack %h ae %b busy %b, want all 0",
                   ifa.reg_wr_addr, ifa.reg_wr_data, ifa.reg_wr_en, ifa.ack_dout, ifa.ack_dout_en, ifa.busy);
        end
      end
      rst = (i == 7);
      set_in(1'b1, fr[i]);
    end
    @(posedge clk); #1;
    set_in(1'b0, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    got = 0;
    foreach (wr_q[i]) if (wr_q[i].d == 0) begin
      n_checks++;
      if (got != 0 || wr_q[i].a !== 12'h500 || wr_q[i].v !== 16'h1122 || wr_q[i].c != s0 + 5) begin
        n_err++; $display("FAIL midreset_write #%0d: got %h/%h at %0d, want only 500/1122 at %0d", got, wr_q[i].a, wr_q[i].v, wr_q[i].c, s0 + 5);
      end
      got++;
    end
    n_checks++;
    if (got != 1) begin n_err++; $display("FAIL midreset_write_count: got %0d want 1", got); end
    n_checks++;
    if (ak_q.size() != 0) begin n_err++; $display("FAIL midreset_ack: got %0d ack bytes want 0", ak_q.size()); end

    fr = '{8'h40, 8'h06, 8'h20, 8'h00, 8'hDE, 8'hAD};
    clear_mon();
    drive_frame(fr, s0, se);
    repeat (7) @(posedge clk);
    #1;
    got = 0;
    foreach (wr_q[i]) if (wr_q[i].d == 0) begin
      n_checks++;
      if (wr_q[i].a !== 12'h620 || wr_q[i].v !== 16'hDEAD) begin
        n_err++; $display("FAIL postreset_write: got %h/%h want 620/DEAD", wr_q[i].a, wr_q[i].v);
      end
      got++;
    end
    n_checks++;
    if (got != 1) begin n_err++; $display("FAIL postreset_write_count: got %0d want 1", got); end
    got = 0;
    foreach (ak_q[i]) if (ak_q[i].d == 0) begin
      m_ack = '{8'hC0, 8'h06, 8'h01, 8'h00};
      if (got < 4) begin
        n_checks++;
        if (ak_q[i].b !== m_ack[got]) begin n_err++; $display("FAIL postreset_ack byte%0d: got %h want %h", got, ak_q[i].b, m_ack[got]); end
      end
      got++;
    end
    n_checks++;
    if (got != 4) begin n_err++; $display("FAIL postreset_ack_count: got %0d want 4", got); end
  endtask

  task automatic test_overlap();
    logic [7:0] f1[$], f2[$], f3[$];
    logic [7:0] ea[4];
    int s0, se, t0, t1, got;
    f1 = '{8'h40, 8'h07, 8'h30, 8'h00, 8'h12, 8'h34};
    f2 = '{8'h40, 8'h08, 8'h00, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    f3 = '{8'h40, 8'h09, 8'h40, 8'h00, 8'hAB, 8'hCD};
    clear_mon();
    drive_frame(f1, s0, se);
    @(posedge clk);
    drive_frame(f2, t0, t1);
    repeat (8) @(posedge clk);
    #1;
    ea = '{8'hC0, 8'h07, 8'h01, 8'h00};
    got = 0;
    foreach (wr_q[i]) if (wr_q[i].d == 0) begin
      n_checks++;
      if (got != 0 || wr_q[i].a !== 12'h730 || wr_q[i].v !== 16'h1234) begin
        n_err++; $display("FAIL overlap_write #%0d: got %h/%h want only 730/1234", got, wr_q[i].a, wr_q[i].v);
      end
      got++;
    end
    n_checks++;
    if (got != 1) begin n_err++; $display("FAIL overlap_write_count: got %0d want 1", got); end
    got = 0;
    foreach (ak_q[i]) if (ak_q[i].d == 0) begin
      if (got < 4) begin
        n_checks++;
        if (ak_q[i].b !== ea[got] || ak_q[i].c != se + got) begin
          n_err++; $display("FAIL overlap_ack byte%0d: got %h at %0d want %h at %0d", got, ak_q[i].b, ak_q[i].c, ea[got], se + got);
        end
      end
      got++;
    end
    n_checks++;
    if (got != 4) begin n_err++; $display("FAIL overlap_ack_count: got %0d want 4", got); end

    clear_mon();
    @(posedge clk);
    drive_frame(f3, s0, se);
    repeat (7) @(posedge clk);
    #1;
    ea = '{8'hC0, 8'h09, 8'h01, 8'h00};
    got = 0;
    foreach (wr_q[i]) if (wr_q[i].d == 0) begin
      n_checks++;
      if (wr_q[i].a !== 12'h940 || wr_q[i].v !== 16'hABCD) begin
        n_err++; $display("FAIL after_overlap_write: got %h/%h want 940/ABCD", wr_q[i].a, wr_q[i].v);
      end
      got++;
    end
    n_checks++;
    if (got != 1) begin n_err++; $display("FAIL after_overlap_write_count: got %0d want 1", got); end
    got = 0;
    foreach (ak_q[i]) if (ak_q[i].d == 0) begin
      if (got < 4) begin
        n_checks++;
        if (ak_q[i].b !== ea[got]) begin n_err++; $display("FAIL after_overlap_ack byte%0d: got %h want %h", got, ak_q[i].b, ea[got]); end
      end
      got++;
    end
    n_checks++;
    if (got != 4) begin n_err++; $display("FAIL after_overlap_ack_count: got %0d want 4", got); end
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 8'h00);
    test_reset();
    test_frames(40);
    test_reset_mid_frame();
    test_overlap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
